// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage constants and the prediction-queue entry layout.
package fetch_pc_gen_pkg;

   localparam int unsigned ADDR_WIDTH  = 32;
   localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1c00_0000;
   localparam int unsigned INSTR_BYTES = 4;

   // One recorded prediction: fetch PC, taken flag, and the PC fetched next.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  taken;
      logic [ADDR_WIDTH-1:0] target;
   } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// Small synchronous FIFO with flush; head entry is visible combinationally.
module pred_fifo
   import fetch_pc_gen_pkg::*;
#(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW:0]    cnt_q;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push;
   logic             do_pop;

   assign full      = (cnt_q == FullCnt);
   assign empty     = (cnt_q == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_data = mem_q[rd_ptr_q];

   // Pointer, count and storage update; flush drops everything queued this cycle too.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + (PtrW + 1)'(1);
         end else if (!do_push && do_pop) begin
            cnt_q <= cnt_q - (PtrW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and next-PC select, recording each fetch's prediction in order.
module fetch_pc_gen #(
   parameter int unsigned            ADDR_WIDTH = fetch_pc_gen_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = fetch_pc_gen_pkg::RESET_PC,
   parameter int unsigned            PQ_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [ADDR_WIDTH-1:0] bpu_pc,
   input  logic                  bpu_branch,
   input  logic [ADDR_WIDTH-1:0] bpu_ppc,
   input  logic                  excp_valid,
   input  logic [ADDR_WIDTH-1:0] excp_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  rs_pop,
   output logic [ADDR_WIDTH-1:0] rs_pc,
   output logic                  rs_pred_taken,
   output logic [ADDR_WIDTH-1:0] rs_pred_target,
   output logic                  pq_empty,
   output logic                  pq_full
);

   import fetch_pc_gen_pkg::*;

   localparam int unsigned EntryW = 2 * ADDR_WIDTH + 1;

   logic                  rst_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic [ADDR_WIDTH-1:0] pc_seq;
   logic [ADDR_WIDTH-1:0] pred_target;
   logic                  flush;
   logic                  fire;
   logic [EntryW-1:0]     push_data;
   logic [EntryW-1:0]     head_data;

   // Instructions are word aligned, so the low two bits never reach the fetch port.
   function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
      return pc & ~ADDR_WIDTH'(3);
   endfunction

   assign flush       = excp_valid | redirect_valid;
   assign if_valid    = ~rst_q & ~pq_full & ~flush;
   assign fire        = if_valid & if_ready;
   assign pc_seq      = pc_q + ADDR_WIDTH'(INSTR_BYTES);
   assign pred_target = bpu_branch ? bpu_ppc : pc_seq;
   assign if_pc       = pc_q;
   assign bpu_pc      = pc_q;
   assign push_data   = {pc_q, bpu_branch, pred_target};

   assign rs_pc          = head_data[EntryW-1 -: ADDR_WIDTH];
   assign rs_pred_taken  = head_data[ADDR_WIDTH];
   assign rs_pred_target = head_data[ADDR_WIDTH-1:0];

   // Next-PC select: exception, then mispredict, then predictor/sequential on fire, else hold.
   always_comb begin
      pc_d = pc_q;
      if (excp_valid) begin
         pc_d = align_pc(excp_pc);
      end else if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end else if (fire) begin
         pc_d = align_pc(pred_target);
      end
   end

   // PC register; rst_q keeps fetch quiet until the cycle after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q <= 1'b1;
         pc_q  <= RESET_PC;
      end else begin
         rst_q <= 1'b0;
         pc_q  <= pc_d;
      end
   end

   pred_fifo #(
      .Width (EntryW),
      .Depth (PQ_DEPTH)
   ) u_pred_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (fire),
      .push_data (push_data),
      .pop       (rs_pop),
      .head_data (head_data),
      .full      (pq_full),
      .empty     (pq_empty)
   );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench: stimulus queues expected fetches/pops, a negedge monitor checks them.
module tb_fetch_pc_gen;
   import fetch_pc_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] bpu_pc;
   logic        bpu_branch;
   logic [31:0] bpu_ppc;
   logic        excp_valid;
   logic [31:0] excp_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        rs_pop;
   logic [31:0] rs_pc;
   logic        rs_pred_taken;
   logic [31:0] rs_pred_target;
   logic        pq_empty;
   logic        pq_full;

   fetch_pc_gen #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h1c00_0000),
      .PQ_DEPTH   (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .bpu_pc         (bpu_pc),
      .bpu_branch     (bpu_branch),
      .bpu_ppc        (bpu_ppc),
      .excp_valid     (excp_valid),
      .excp_pc        (excp_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rs_pop         (rs_pop),
      .rs_pc          (rs_pc),
      .rs_pred_taken  (rs_pred_taken),
      .rs_pred_target (rs_pred_target),
      .pq_empty       (pq_empty),
      .pq_full        (pq_full)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_fetch_q [$];
   pred_entry_t exp_rs_q [$];
   pred_entry_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic pred_entry_t ent(input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt);
      pred_entry_t e;
      e.pc     = pc;
      e.taken  = tk;
      e.target = tgt;
      return e;
   endfunction

   // Monitor: every accepted fetch and every effective pop is checked against the queues.
   always @(negedge clk) begin
      if (if_valid && if_ready) begin
         if (exp_fetch_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch: unexpected fire at pc %h", if_pc);
         end else begin
            check("fetch_pc", {32'h0, if_pc}, {32'h0, exp_fetch_q.pop_front()});
         end
      end
      if (!rst && rs_pop && !pq_empty && !redirect_valid && !excp_valid) begin
         if (exp_rs_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop: unexpected pop, rs_pc %h", rs_pc);
         end else begin
            mon_e = exp_rs_q.pop_front();
            check("rs_pc", {32'h0, rs_pc}, {32'h0, mon_e.pc});
            check("rs_taken", {63'h0, rs_pred_taken}, {63'h0, mon_e.taken});
            check("rs_target", {32'h0, rs_pred_target}, {32'h0, mon_e.target});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_ready = 1'b1; bpu_branch = 1'b0; bpu_ppc = '0;
      excp_valid = 1'b0; excp_pc = '0; redirect_valid = 1'b0; redirect_pc = '0; rs_pop = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_if_pc", {32'h0, if_pc}, 64'h1c00_0000);
      check("rst_bpu_pc", {32'h0, bpu_pc}, 64'h1c00_0000);
      check("rst_if_valid", {63'h0, if_valid}, 64'h0);
      check("rst_empty", {63'h0, pq_empty}, 64'h1);
      check("rst_full", {63'h0, pq_full}, 64'h0);
      check("rst_rs_pc", {32'h0, rs_pc}, 64'h0);
      check("rst_rs_taken", {63'h0, rs_pred_taken}, 64'h0);
      check("rst_rs_target", {32'h0, rs_pred_target}, 64'h0);
      next_cycle();

      // Sequential fetch until the queue is full.
      rst = 1'b0;
      exp_fetch_q.push_back(32'h1c00_0000);
      exp_fetch_q.push_back(32'h1c00_0004);
      exp_fetch_q.push_back(32'h1c00_0008);
      exp_fetch_q.push_back(32'h1c00_000c);
      @(negedge clk);
      check("first_req_delay", {63'h0, if_valid}, 64'h0);
      next_cycle();
      @(negedge clk);
      check("first_req", {63'h0, if_valid}, 64'h1);
      check("first_bpu_pc", {32'h0, bpu_pc}, 64'h1c00_0000);
      for (int i = 0; i < 4; i++) next_cycle();

      // Full: fetch stalls; drain all four entries with the fetch port closed.
      if_ready = 1'b0;
      rs_pop = 1'b1;
      for (int i = 0; i < 4; i++)
         exp_rs_q.push_back(ent(32'h1c00_0000 + 32'(4 * i), 1'b0, 32'h1c00_0004 + 32'(4 * i)));
      @(negedge clk);
      check("full_flag", {63'h0, pq_full}, 64'h1);
      check("full_no_valid", {63'h0, if_valid}, 64'h0);
      check("full_if_pc", {32'h0, if_pc}, 64'h1c00_0010);
      for (int i = 0; i < 4; i++) next_cycle();
      rs_pop = 1'b0;

      // Redirect to 1c000008, then a predicted-taken fetch there.
      redirect_valid = 1'b1; redirect_pc = 32'h1c00_0008;
      @(negedge clk);
      check("drained_empty", {63'h0, pq_empty}, 64'h1);
      check("redir_no_valid", {63'h0, if_valid}, 64'h0);
      next_cycle();
      redirect_valid = 1'b0;
      if_ready = 1'b1; bpu_branch = 1'b1; bpu_ppc = 32'h1c00_0100;
      exp_fetch_q.push_back(32'h1c00_0008);
      @(negedge clk);
      check("redir_pc", {32'h0, if_pc}, 64'h1c00_0008);
      check("redir_valid", {63'h0, if_valid}, 64'h1);
      next_cycle();
      bpu_branch = 1'b0;
      exp_fetch_q.push_back(32'h1c00_0100);
      @(negedge clk);
      check("pred_target_pc", {32'h0, if_pc}, 64'h1c00_0100);
      next_cycle();
      if_ready = 1'b0; rs_pop = 1'b1;
      exp_rs_q.push_back(ent(32'h1c00_0008, 1'b1, 32'h1c00_0100));
      @(negedge clk);
      check("seq_after_pred", {32'h0, if_pc}, 64'h1c00_0104);
      next_cycle();

      // Mispredict redirect together with a fire attempt and a pop: both discarded.
      if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1c00_0203;
      @(negedge clk);
      check("mispred_no_valid", {63'h0, if_valid}, 64'h0);
      next_cycle();
      rs_pop = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
      @(negedge clk);
      check("mispred_pc_align", {32'h0, if_pc}, 64'h1c00_0200);
      check("mispred_flush", {63'h0, pq_empty}, 64'h1);
      check("mispred_valid", {63'h0, if_valid}, 64'h1);
      next_cycle();

      // Exception beats redirect.
      excp_valid = 1'b1; excp_pc = 32'h1c00_1000;
      redirect_valid = 1'b1; redirect_pc = 32'h1c00_0300;
      next_cycle();
      excp_valid = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      check("excp_wins", {32'h0, if_pc}, 64'h1c00_1000);

      // Backpressure for 5 cycles with a toggling prediction.
      bpu_ppc = 32'h1c00_beec;
      for (int i = 0; i < 5; i++) begin
         bpu_branch = (i % 2 == 0);
         @(negedge clk);
         check("bp_pc_hold", {32'h0, if_pc}, 64'h1c00_1000);
         check("bp_no_push", {63'h0, pq_empty}, 64'h1);
         next_cycle();
      end
      bpu_branch = 1'b0;

      // Wrap-around of PC+4.
      redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
      next_cycle();
      redirect_valid = 1'b0; if_ready = 1'b1;
      exp_fetch_q.push_back(32'hffff_fffc);
      @(negedge clk);
      check("wrap_start", {32'h0, if_pc}, 64'hffff_fffc);
      next_cycle();
      if_ready = 1'b0; rs_pop = 1'b1;
      exp_rs_q.push_back(ent(32'hffff_fffc, 1'b0, 32'h0000_0000));
      @(negedge clk);
      check("wrap_pc", {32'h0, if_pc}, 64'h0);
      next_cycle();

      // Pop while empty must not move the read pointer (stale head is slot 1).
      @(negedge clk);
      check("empty_before", {63'h0, pq_empty}, 64'h1);
      check("stale_head", {32'h0, rs_pc}, 64'h1c00_0100);
      next_cycle();
      rs_pop = 1'b0; if_ready = 1'b1;
      exp_fetch_q.push_back(32'h0000_0000);
      @(negedge clk);
      check("empty_pop_empty", {63'h0, pq_empty}, 64'h1);
      check("empty_pop_full", {63'h0, pq_full}, 64'h0);
      check("empty_pop_head", {32'h0, rs_pc}, 64'h1c00_0100);
      check("empty_pop_tgt", {32'h0, rs_pred_target}, 64'h1c00_0104);
      next_cycle();
      if_ready = 1'b0; rs_pop = 1'b1;
      exp_rs_q.push_back(ent(32'h0000_0000, 1'b0, 32'h0000_0004));
      @(negedge clk);
      check("after_push_nonempty", {63'h0, pq_empty}, 64'h0);
      next_cycle();

      // Reset mid-operation with an entry queued.
      rs_pop = 1'b0; if_ready = 1'b1;
      exp_fetch_q.push_back(32'h0000_0004);
      next_cycle();
      if_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("pre_rst_nonempty", {63'h0, pq_empty}, 64'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_pc", {32'h0, if_pc}, 64'h1c00_0000);
      check("mid_rst_valid", {63'h0, if_valid}, 64'h0);
      check("mid_rst_empty", {63'h0, pq_empty}, 64'h1);
      check("mid_rst_rs_pc", {32'h0, rs_pc}, 64'h0);
      check("mid_rst_rs_target", {32'h0, rs_pred_target}, 64'h0);
      next_cycle();
      @(negedge clk);
      check("post_rst_valid", {63'h0, if_valid}, 64'h1);
      check("post_rst_pc", {32'h0, if_pc}, 64'h1c00_0000);
      next_cycle();

      check("fetch_left", 64'(exp_fetch_q.size()), 64'h0);
      check("pops_left", 64'(exp_rs_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator sitting directly upstream of the branch predictor. It owns the architectural fetch PC, drives it to the predictor and the instruction fetch port, and chooses the next PC from exception redirects, mispredict redirects, the predictor's taken target, or sequential PC+4. Every fetched PC's prediction is recorded in a small in-order queue. Execute pops that queue to check the prediction against the resolved outcome.

## Interface
- `ADDR_WIDTH`, default `32`: PC width, equal to the codebase address width.
- `RESET_PC`, default `32'h1c00_0000`: first fetch address after reset.
- `PQ_DEPTH`, default `4`: number of prediction-queue entries, a power of two and at least 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_valid` out 1: `if_pc` is a valid fetch request.
- `if_ready` in 1: fetch port accepts the request. Fire = `if_valid & if_ready`.
- `if_pc` out `ADDR_WIDTH`: current fetch PC.
- `bpu_pc` out `ADDR_WIDTH`: lookup PC to the predictor; always equals `if_pc`.
- `bpu_branch` in 1: predictor says taken, combinational from `bpu_pc`.
- `bpu_ppc` in `ADDR_WIDTH`: predicted target.
- `excp_valid` in 1: exception or ertn redirect.
- `excp_pc` in `ADDR_WIDTH`: exception target.
- `redirect_valid` in 1: branch mispredict redirect from execute.
- `redirect_pc` in `ADDR_WIDTH`: corrected PC.
- `rs_pop` in 1: execute consumes the head prediction.
- `rs_pc` out `ADDR_WIDTH`: head entry PC.
- `rs_pred_taken` out 1: head entry predicted-taken flag.
- `rs_pred_target` out `ADDR_WIDTH`: head entry predicted target. Holds `if_pc+4` when the entry was predicted not-taken.
- `pq_empty` out 1: queue empty.
- `pq_full` out 1: queue full.

## Operation
- **Next-PC priority, highest first:**
  - `excp_valid` → `excp_pc`
  - `redirect_valid` → `redirect_pc`
  - fire with `bpu_branch` → `bpu_ppc`
  - fire without `bpu_branch` → `if_pc + 4`
  - otherwise hold `if_pc`
- **Alignment:** PC bits [1:0] are forced to 0 on every load.
- **Fetch request:** `if_valid = !rst_q & !pq_full & !excp_valid & !redirect_valid`. `rst_q` is a register that is 1 during reset and 0 afterwards.
- **Push:** on fire, push `{if_pc, bpu_branch, bpu_branch ? bpu_ppc : if_pc+4}` into the queue.
- **Pop:** `rs_pop` while `pq_empty` is ignored. A pop while full and a push in the same cycle cannot coincide, because `if_valid` is low while full.
- **Simultaneous push and pop:** allowed when neither full nor empty. The count is unchanged and both pointers advance.
- **Flush:** `excp_valid` or `redirect_valid` clears the queue at the clock edge. Pointers and count go to 0. Any push or pop in that cycle is discarded.
- **Addition:** `if_pc + 4` wraps modulo 2^`ADDR_WIDTH` with no carry out.
- **Handshake:** when `if_ready` is low, `if_pc` and `if_valid` hold stable. Only a redirect may change `if_pc` while `if_valid` is high and unaccepted.

## Timing
- **Reset values:**
  - `if_pc = bpu_pc = RESET_PC`
  - `if_valid = 0`
  - `pq_empty = 1`, `pq_full = 0`
  - `rs_pc`, `rs_pred_target` = 0 and `rs_pred_taken = 0`, because the queue RAM is cleared
- **First request:** `if_valid` rises in the first cycle after `rst` deasserts.
- **Redirect latency:** a redirect asserted in cycle t puts the new PC on `if_pc` with `if_valid = 1` in cycle t+1. This is one bubble.
- **Prediction latency:** zero-cycle use. The predicted target is fetched in the cycle after the fire.
- **Pop timing:** `rs_*` reflect the head combinationally from the queue. A pop in cycle t exposes the next entry in t+1.
- **Full flag:** `pq_full` asserted in cycle t blocks fire in t. A pop in t frees a slot for t+1, not t.
- **Reset mid-operation:** `rst` overrides everything. It restores the reset values at the next edge, drops any queued predictions, and cancels any pending handshake.

## Structure
- **Shared package:** `ADDR_WIDTH` (from the width header), `RESET_PC`, and a `pred_entry_t` struct `{pc, taken, target}`.
- **Sub-module:** `pred_fifo`, a parameterised sync FIFO with push, pop, flush, full, empty and head data. The remaining RTL is the PC register and the next-PC mux.

## Test plan
- **Reset then sequential fetch:** `rst` high 2 cycles, then low, with `if_ready = 1` and no predictions. Fetched PCs are 1c000000, 1c000004, 1c000008, and the queue fills to full after 4 fires, then `if_valid` drops.
- **Predicted taken:** `bpu_branch = 1`, `bpu_ppc = 1c000100` at PC 1c000008. The next `if_pc` is 1c000100, and the queue entry is `{1c000008, 1, 1c000100}`.
- **Mispredict redirect with pop:** `redirect_valid` with `redirect_pc = 1c000203` in the same cycle as a fire and an `rs_pop`. `if_pc` becomes 1c000200 (bits [1:0] forced to 0), the queue is empty, the fire and pop are discarded, and `if_valid` returns high one cycle later.
- **Exception beats redirect:** `excp_valid` (`excp_pc = 1c001000`) and `redirect_valid` in the same cycle. `if_pc` becomes 1c001000.
- **Backpressure:** `if_ready = 0` for 5 cycles. `if_pc` is stable, nothing is pushed, and a `bpu_branch` toggle has no effect.
- **Wrap and pop corners:**
  - PC ffff_fffc, not taken, fire → next `if_pc` 0000_0000.
  - `rs_pop` while empty → no state change.
